manchester_tx: RTL and testbench

Parametrised Manchester line encoder, successor to the single-bit Mealy encoder. It accepts DATA_W-bit words over a valid/ready handshake, prepends an optional alternating preamble, and serialises each frame as Manchester half-bits, one half-bit per clk cycle. The output is registered, so the line is glitch-free. Selectable coding convention, bit order and idle level. It sits between a byte/word source and the line driver of the serial link.

---
 rtl/manchester_tx_if.sv | 12 +
 rtl/manchester_tx.sv | 137 +++++++++++++
 tb/tb_manchester_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_tx_if.sv
// Word handshake between a data source and the Manchester encoder.
// The source drives in_data/in_valid; the encoder answers with in_ready.
interface manchester_tx_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/manchester_tx.sv
// Manchester line encoder: optional alternating preamble, then DATA_W payload
// bits, one registered half-bit per clock, with zero-gap back-to-back frames.
module manchester_tx #(
   parameter int   DATA_W        = 8,
   parameter int   PREAMBLE_BITS = 2,
   parameter int   CONVENTION    = 0,
   parameter int   MSB_FIRST     = 1,
   parameter logic IDLE_LEVEL    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   manchester_tx_if.slave    s,
   output logic              z,
   output logic              z_en,
   output logic              busy,
   output logic              done
);
   localparam int MAX_BITS = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic ENC_INV = (CONVENTION == 0);

   typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA} state_t;

   state_t            state_reg, state_next;
   logic              phase_reg, phase_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic              z_reg, z_next;
   logic              z_en_reg, z_en_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              next_bit;
   logic              cur_bit;
   logic              accept;

   function automatic logic head(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
   endfunction

   // First half of a bit is b^ENC_INV, second half is its complement.
   function automatic logic enc(input logic b, input logic ph);
      return b ^ ph ^ ENC_INV;
   endfunction

   // done_reg marks the last half-bit, which is also the reload slot.
   assign s.in_ready = !rst && (state_reg == ST_IDLE || done_reg);
   assign accept     = s.in_valid && s.in_ready;
   assign cur_bit    = (state_reg == ST_PREAMBLE) ? ~cnt_reg[0] : head(shift_reg);

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      z_next     = IDLE_LEVEL;
      z_en_next  = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      next_bit   = 1'b0;
      if (accept) begin
         if (PREAMBLE_BITS > 0) begin
            state_next = ST_PREAMBLE;
            next_bit   = 1'b1;
         end else begin
            state_next = ST_DATA;
            next_bit   = head(s.in_data);
         end
         phase_next = 1'b0;
         cnt_next   = '0;
         shift_next = s.in_data;
         z_next     = enc(next_bit, 1'b0);
         z_en_next  = 1'b1;
         busy_next  = 1'b1;
      end else if (state_reg == ST_IDLE || done_reg) begin
         state_next = ST_IDLE;
         phase_next = 1'b0;
         cnt_next   = '0;
         shift_next = '0;
      end else if (!phase_reg) begin
         phase_next = 1'b1;
         z_next     = enc(cur_bit, 1'b1);
         z_en_next  = 1'b1;
         busy_next  = 1'b1;
         done_next  = (state_reg == ST_DATA) && (cnt_reg == DATA_LAST);
      end else begin
         phase_next = 1'b0;
         z_en_next  = 1'b1;
         busy_next  = 1'b1;
         if (state_reg == ST_PREAMBLE && cnt_reg == PRE_LAST) begin
            state_next = ST_DATA;
            cnt_next   = '0;
            next_bit   = head(shift_reg);
         end else if (state_reg == ST_PREAMBLE) begin
            cnt_next   = cnt_reg + CNT_W'(1);
            next_bit   = cnt_reg[0];
         end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
            shift_next = advance(shift_reg);
            next_bit   = head(advance(shift_reg));
         end
         z_next = enc(next_bit, 1'b0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         phase_reg <= 1'b0;
         cnt_reg   <= '0;
         shift_reg <= '0;
         z_reg     <= IDLE_LEVEL;
         z_en_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
         z_reg     <= z_next;
         z_en_reg  <= z_en_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign z    = z_reg;
   assign z_en = z_en_reg;
   assign busy = busy_reg;
   assign done = done_reg;
endmodule

// File: tb/tb_manchester_tx.sv
// Self-checking bench for manchester_tx: three parameter sets driven from one
// set of scenario tasks, compared against a frame-level half-bit model.
module tb_manchester_tx;
   logic       clk;
   logic       rst;
   logic [2:0] vld;
   logic [7:0] data_drv;
   int         sel;

   // Per-instance parameters, indexed by sel.
   int P  [3] = '{2, 0, 3};
   int DW [3] = '{8, 6, 8};
   int CV [3] = '{0, 1, 0};
   int MB [3] = '{1, 0, 0};
   int IL [3] = '{0, 0, 1};

   manchester_tx_if #(.DATA_W(8)) s0 ();
   manchester_tx_if #(.DATA_W(6)) s1 ();
   manchester_tx_if #(.DATA_W(8)) s2 ();

   logic z0, ze0, b0, d0;
   logic z1, ze1, b1, d1;
   logic z2, ze2, b2, d2;

   assign s0.in_data  = data_drv;
   assign s1.in_data  = data_drv[5:0];
   assign s2.in_data  = data_drv;
   assign s0.in_valid = vld[0];
   assign s1.in_valid = vld[1];
   assign s2.in_valid = vld[2];

   manchester_tx #(.DATA_W(8), .PREAMBLE_BITS(2), .CONVENTION(0), .MSB_FIRST(1), .IDLE_LEVEL(1'b0))
      u0 (.clk(clk), .rst(rst), .s(s0), .z(z0), .z_en(ze0), .busy(b0), .done(d0));
   manchester_tx #(.DATA_W(6), .PREAMBLE_BITS(0), .CONVENTION(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0))
      u1 (.clk(clk), .rst(rst), .s(s1), .z(z1), .z_en(ze1), .busy(b1), .done(d1));
   manchester_tx #(.DATA_W(8), .PREAMBLE_BITS(3), .CONVENTION(0), .MSB_FIRST(0), .IDLE_LEVEL(1'b1))
      u2 (.clk(clk), .rst(rst), .s(s2), .z(z2), .z_en(ze2), .busy(b2), .done(d2));

   logic z_o, ze_o, b_o, d_o, rdy_o;
   always_comb begin
      z_o = z2; ze_o = ze2; b_o = b2; d_o = d2; rdy_o = s2.in_ready;
      case (sel)
         0: begin z_o = z0; ze_o = ze0; b_o = b0; d_o = d0; rdy_o = s0.in_ready; end
         1: begin z_o = z1; ze_o = ze1; b_o = b1; d_o = d1; rdy_o = s1.in_ready; end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0]  w [4];
   logic [63:0] cap;

   // Reference: the whole half-bit sequence of a frame, built from the coding rules.
   function automatic void build_frame(input int s, input logic [7:0] word, inout bit q[$]);
      bit b;
      int idx;
      for (int i = 0; i < P[s]; i++) begin
         b = (i % 2 == 0);
         if (CV[s] == 0) begin q.push_back(!b); q.push_back(b); end
         else begin q.push_back(b); q.push_back(!b); end
      end
      for (int j = 0; j < DW[s]; j++) begin
         idx = (MB[s] != 0) ? DW[s] - 1 - j : j;
         b = word[idx];
         if (CV[s] == 0) begin q.push_back(!b); q.push_back(b); end
         else begin q.push_back(b); q.push_back(!b); end
      end
   endfunction

   task automatic run_stream(input string name, input int nwords);
      bit exp_q[$];
      int L;
      int total;
      bit last_half;
      L = 2 * (P[sel] + DW[sel]);
      for (int i = 0; i < nwords; i++) build_frame(sel, w[i], exp_q);
      total = nwords * L;
      cap = '0;
      @(negedge clk);
      n_checks++;
      if (rdy_o !== 1'b1) $display("FAIL %s ready_before_accept got %b want 1", name, rdy_o);
      else n_pass++;
      vld[sel] = 1'b1;
      data_drv = w[0];
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         last_half = (k % L == L - 1);
         if (k % L == 0) begin
            if (k / L + 1 < nwords) data_drv = w[k / L + 1];
            else begin vld[sel] = 1'b0; data_drv = 8'($urandom); end
         end
         cap = {cap[62:0], z_o};
         n_checks++;
         if (z_o !== exp_q[k]) $display("FAIL %s z k=%0d got %b want %b", name, k, z_o, exp_q[k]);
         else n_pass++;
         n_checks++;
         if (ze_o !== 1'b1 || b_o !== 1'b1)
            $display("FAIL %s z_en_busy k=%0d got %b%b want 11", name, k, ze_o, b_o);
         else n_pass++;
         n_checks++;
         if (d_o !== last_half || rdy_o !== last_half)
            $display("FAIL %s done_ready k=%0d got %b%b want %b%b", name, k, d_o, rdy_o, last_half, last_half);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (z_o !== 1'(IL[sel]) || ze_o !== 1'b0 || b_o !== 1'b0 || d_o !== 1'b0 || rdy_o !== 1'b1)
         $display("FAIL %s after_frame z/z_en/busy/done/ready got %b%b%b%b%b want %0d0001",
                  name, z_o, ze_o, b_o, d_o, rdy_o, IL[sel]);
      else n_pass++;
      $display("stream %s: sel=%0d words=%0d cycles=%0d", name, sel, nwords, total);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vld = 3'b111;
      data_drv = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (s0.in_ready !== 1'b0 || s1.in_ready !== 1'b0 || s2.in_ready !== 1'b0)
            $display("FAIL reset_ready got %b%b%b want 000", s0.in_ready, s1.in_ready, s2.in_ready);
         else n_pass++;
         n_checks++;
         if ({z0, ze0, b0, d0} !== 4'b0000 || {z2, ze2, b2, d2} !== 4'b1000)
            $display("FAIL reset_outputs got u0=%b%b%b%b u2=%b%b%b%b want 0000/1000",
                     z0, ze0, b0, d0, z2, ze2, b2, d2);
         else n_pass++;
      end
      rst = 1'b0;
      vld = 3'b000;
      @(negedge clk);
      n_checks++;
      if (s0.in_ready !== 1'b1 || z0 !== 1'b0 || z2 !== 1'b1 || ze0 !== 1'b0)
         $display("FAIL reset_release got ready=%b z0=%b z2=%b ze0=%b want 1 0 1 0",
                  s0.in_ready, z0, z2, ze0);
      else n_pass++;
      $display("reset: held 3 cycles with in_valid high, released");
   endtask

   task automatic test_single_frame();
      sel = 0;
      w[0] = 8'hE4;
      run_stream("single_E4", 1);
      n_checks++;
      if (cap[19:0] !== 20'b01100101011010011010)
         $display("FAIL single_E4_pattern got %b want 01100101011010011010", cap[19:0]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      sel = 0;
      w[0] = 8'hE4;
      w[1] = 8'h39;
      run_stream("b2b_E4_39", 2);
      for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
      run_stream("b2b_random", 3);
   endtask

   task automatic test_convention_order();
      sel = 1;
      w[0] = 8'h27;
      run_stream("conv1_lsb", 1);
      n_checks++;
      if (cap[11:0] !== 12'b101010010110)
         $display("FAIL conv1_lsb_pattern got %b want 101010010110", cap[11:0]);
      else n_pass++;
      for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
      run_stream("conv1_random", 3);
   endtask

   task automatic test_idle_level();
      sel = 2;
      for (int i = 0; i < 2; i++) w[i] = 8'($urandom);
      run_stream("idle1_random", 2);
      w[0] = 8'($urandom);
      run_stream("idle1_single", 1);
   endtask

   task automatic test_reset_midframe();
      int done_seen;
      sel = 0;
      @(negedge clk);
      vld[0] = 1'b1;
      data_drv = 8'hE4;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) vld[0] = 1'b0;
      end
      n_checks++;
      if (ze_o !== 1'b1 || b_o !== 1'b1)
         $display("FAIL midframe_active got z_en=%b busy=%b want 1 1", ze_o, b_o);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (z_o !== 1'b0 || ze_o !== 1'b0 || b_o !== 1'b0 || d_o !== 1'b0 || rdy_o !== 1'b0)
         $display("FAIL midframe_abort z/z_en/busy/done/ready got %b%b%b%b%b want 00000",
                  z_o, ze_o, b_o, d_o, rdy_o);
      else n_pass++;
      rst = 1'b0;
      done_seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (d_o !== 1'b0 || ze_o !== 1'b0) done_seen++;
      end
      n_checks++;
      if (done_seen != 0) $display("FAIL midframe_quiet got %0d active cycles want 0", done_seen);
      else n_pass++;
      $display("reset_midframe: aborted E4 frame at cycle 7");
      w[0] = 8'($urandom);
      run_stream("after_abort", 1);
   endtask

   initial begin
      rst = 1'b1;
      vld = 3'b000;
      data_drv = 8'h00;
      sel = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_convention_order();
      test_idle_level();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
